// File: rtl/cracker_pkg.sv
// Shared types and defaults for the hint-guided lock cracker.
// State encoding, default sizing and width helpers.
package cracker_pkg;

  localparam int unsigned WIDTH_D      = 10;
  localparam int unsigned HINT_W_D     = 4;
  localparam int unsigned SETTLE_D     = 2;
  localparam int unsigned ENTER_HOLD_D = 4;
  localparam int unsigned TIMEOUT_D    = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_INIT,
    S_BASE,
    S_PROBE,
    S_JUDGE,
    S_PRESS,
    S_WAIT_OPEN,
    S_FIN
  } cracker_state_t;

  // Bit index runs 0..width, so it needs room for width itself.
  function automatic int unsigned idx_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // One timer serves every wait, so size it for the longest one.
  function automatic int unsigned tmr_w(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hint_guided_cracker_timer.sv
// Loadable down-counter with zero flag.
// Shared by the settle, enter-hold and open-timeout waits.
module cracker_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hint_guided_cracker.sv
// Greedy single-bit lock cracker driving attempt/ENTER from the hint.
// CRACKER_EARLY_EXIT_EN: stop probing once the hint reaches zero.
module hint_guided_cracker
  import cracker_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_D,
  parameter int unsigned HINT_W     = HINT_W_D,
  parameter int unsigned SETTLE     = SETTLE_D,
  parameter int unsigned ENTER_HOLD = ENTER_HOLD_D,
  parameter int unsigned TIMEOUT    = TIMEOUT_D
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESETN,
  input  logic              start,
  input  logic [HINT_W-1:0] hint,
  input  logic              is_locked,
  output logic [WIDTH-1:0]  attempt,
  output logic              enter,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [HINT_W-1:0] probe_cnt
);

  localparam int unsigned IW = idx_w(WIDTH);
  localparam int unsigned TW = tmr_w(SETTLE, ENTER_HOLD, TIMEOUT);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(ENTER_HOLD - 1);
  localparam logic [TW-1:0] TMO_LD    = TW'(TIMEOUT - 1);

  localparam logic [IW-1:0]     IDX_LAST  = IW'(WIDTH - 1);
  localparam logic [HINT_W-1:0] PROBE_MAX = HINT_W'(WIDTH);
  localparam logic [WIDTH-1:0]  ONE_HOT0  = WIDTH'(1);

  cracker_state_t    state_q, state_d;
  logic [WIDTH-1:0]  attempt_q, attempt_d;
  logic              enter_q, enter_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              success_q, success_d;
  logic [HINT_W-1:0] probe_q, probe_d;
  logic [HINT_W-1:0] base_q, base_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic              tmr_ld;
  logic [TW-1:0]     tmr_val;
  logic              tmr_zero;

  logic [HINT_W-1:0] h_in;
  logic [WIDTH-1:0]  cur_mask;
  logic [WIDTH-1:0]  nxt_mask;
  logic              keep;
  logic [HINT_W-1:0] base_nxt;
  logic [WIDTH-1:0]  att_nxt;
  logic              last;
  logic              early;

  cracker_timer #(
    .W (TW)
  ) u_timer (
    .clk_i  (MAX10_CLK1_50),
    .rst_ni (RESETN),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  assign h_in     = hint;
  assign cur_mask = ONE_HOT0 << idx_q;
  assign nxt_mask = cur_mask << 1;

  // A probe is kept only if it strictly lowers the mismatch count.
  assign keep     = h_in < base_q;
  assign base_nxt = keep ? h_in : base_q;
  assign att_nxt  = keep ? attempt_q : (attempt_q ^ cur_mask);
  assign last     = (idx_q == IDX_LAST);

`ifdef CRACKER_EARLY_EXIT_EN
  assign early = keep && (h_in == '0);
`else
  assign early = 1'b0;
`endif

  // Next-state and output decode for the cracking sequence.
  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    enter_d   = enter_q;
    busy_d    = busy_q;
    done_d    = done_q;
    success_d = success_q;
    probe_d   = probe_q;
    base_d    = base_q;
    idx_d     = idx_q;
    tmr_ld    = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          success_d = 1'b0;
          probe_d   = '0;
          attempt_d = '0;
        end
      end
      S_CHECK: begin
        // Pressing an open lock would re-lock it with a new password.
        if (!is_locked) begin
          state_d   = S_FIN;
          success_d = 1'b1;
        end else begin
          state_d   = S_INIT;
          attempt_d = '0;
          idx_d     = '0;
          tmr_ld    = 1'b1;
          tmr_val   = SETTLE_LD;
        end
      end
      S_INIT: begin
        if (tmr_zero) begin
          state_d = S_BASE;
        end
      end
      S_BASE: begin
        base_d = h_in;
        if (h_in == '0) begin
          state_d = S_PRESS;
          enter_d = 1'b1;
          tmr_ld  = 1'b1;
          tmr_val = HOLD_LD;
        end else begin
          state_d   = S_PROBE;
          attempt_d = attempt_q ^ cur_mask;
          tmr_ld    = 1'b1;
          tmr_val   = SETTLE_LD;
        end
      end
      S_PROBE: begin
        if (tmr_zero) begin
          state_d = S_JUDGE;
          if (probe_q != PROBE_MAX) begin
            probe_d = probe_q + 1'b1;
          end
        end
      end
      S_JUDGE: begin
        base_d = base_nxt;
        idx_d  = idx_q + 1'b1;
        if (last || early) begin
          state_d   = S_PRESS;
          attempt_d = att_nxt;
          enter_d   = (base_nxt == '0);
          tmr_ld    = 1'b1;
          tmr_val   = HOLD_LD;
        end else begin
          // Revert and next toggle share one settle window.
          state_d   = S_PROBE;
          attempt_d = att_nxt ^ nxt_mask;
          tmr_ld    = 1'b1;
          tmr_val   = SETTLE_LD;
        end
      end
      S_PRESS: begin
        if (base_q != '0) begin
          state_d   = S_FIN;
          success_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = S_WAIT_OPEN;
          enter_d = 1'b0;
          tmr_ld  = 1'b1;
          tmr_val = TMO_LD;
        end
      end
      S_WAIT_OPEN: begin
        if (!is_locked) begin
          state_d   = S_FIN;
          success_d = 1'b1;
        end else if (tmr_zero) begin
          state_d   = S_FIN;
          success_d = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops enter immediately.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      attempt_q <= '0;
      enter_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      probe_q   <= '0;
      base_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      enter_q   <= enter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      success_q <= success_d;
      probe_q   <= probe_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
    end
  end

  assign attempt   = attempt_q;
  assign enter     = enter_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign success   = success_q;
  assign probe_cnt = probe_q;

endmodule

// File: tb/tb_hint_guided_cracker.sv
// Self-checking bench for hint_guided_cracker with a behavioural lock.
// Honours CRACKER_EARLY_EXIT_EN when computing expected probe counts.
module tb_hint_guided_cracker;

  localparam int W    = 10;
  localparam int HW   = 4;
  localparam int HOLD = 4;
  localparam int TO   = 16;
`ifdef CRACKER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [HW-1:0] lk_hint;
  logic          is_locked;
  logic [W-1:0]  attempt;
  logic          enter, busy, done, success;
  logic [HW-1:0] probe_cnt;

  always #5 clk = ~clk;

  hint_guided_cracker dut (
    .MAX10_CLK1_50 (clk),
    .RESETN        (rst_n),
    .start         (start),
    .hint          (lk_hint),
    .is_locked     (is_locked),
    .attempt       (attempt),
    .enter         (enter),
    .busy          (busy),
    .done          (done),
    .success       (success),
    .probe_cnt     (probe_cnt)
  );

  // Lock model
  logic [W-1:0] pw = '0;
  bit           stuck = 1'b0;
  bit           never_open = 1'b0;
  bit           force_open = 1'b0;
  bit           rel_clr = 1'b0;
  logic         opened = 1'b0;
  logic         enter_p = 1'b0;
  int           enter_cyc = 0;
  logic [W-1:0] press_att = '0;
  bit           unstable = 1'b0;

  always @(posedge clk) begin
    lk_hint <= stuck ? HW'(5) : HW'($countones(attempt ^ pw));
    enter_p <= enter;
    if (rel_clr) begin
      opened    <= 1'b0;
      enter_cyc <= 0;
      unstable  <= 1'b0;
    end else begin
      if (enter) begin
        enter_cyc <= enter_cyc + 1;
        if (enter_cyc == 0) press_att <= attempt;
        else if (attempt != press_att) unstable <= 1'b1;
      end
      if (enter_p && !enter && attempt == pw && !never_open)
        opened <= 1'b1;
    end
  end

  assign is_locked = !(opened || force_open);

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] pw;
    bit           stuck;
    bit           nopen;
    bit           fopen;
    logic [W-1:0] e_att;
    bit           e_succ;
    int           e_probe;
    int           e_enter;
  } vec_t;

  // Outcome from the lock's rules: greedy probing converges on pw.
  function automatic vec_t model(input logic [W-1:0] p, input bit s,
                                 input bit no, input bit fo);
    vec_t v;
    int   msb;
    v.pw = p; v.stuck = s; v.nopen = no; v.fopen = fo;
    if (fo) begin
      v.e_att = '0; v.e_succ = 1'b1; v.e_probe = 0; v.e_enter = 0;
    end else if (s) begin
      v.e_att = '0; v.e_succ = 1'b0; v.e_probe = W; v.e_enter = 0;
    end else begin
      msb = -1;
      for (int b = 0; b < W; b++) if (p[b]) msb = b;
      v.e_att   = p;
      v.e_probe = (msb < 0) ? 0 : (EE ? msb + 1 : W);
      v.e_enter = HOLD;
      v.e_succ  = !no;
    end
    return v;
  endfunction

  task automatic clr_lock();
    rel_clr = 1'b1;
    @(posedge clk); #1;
    rel_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input vec_t v, input int id);
    int k, kfall, kdone;
    bit prev_en;
    string tag;
    tag = $sformatf("v%0d", id);
    pw = v.pw; stuck = v.stuck;
    never_open = v.nopen; force_open = v.fopen;
    clr_lock();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; kfall = -1; kdone = -1;
    chk({tag, "_busy"}, busy, 1);
    prev_en = enter;
    while (kdone < 0 && k < 600) begin
      if (k == 3 && busy) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (prev_en && !enter) kfall = k;
      prev_en = enter;
      if (done) kdone = k;
    end
    chk({tag, "_done_seen"}, kdone >= 0, 1);
    chk({tag, "_attempt"}, attempt, v.e_att);
    chk({tag, "_success"}, success, v.e_succ);
    chk({tag, "_probe"}, probe_cnt, v.e_probe);
    chk({tag, "_enter_cyc"}, enter_cyc, v.e_enter);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_stable"}, unstable, 0);
    if (v.e_enter > 0) chk({tag, "_press_att"}, press_att, v.e_att);
    if (v.fopen) chk({tag, "_latency"}, kdone, 2);
    if (v.nopen && v.e_enter > 0)
      chk({tag, "_tmo_gap"}, kdone - kfall, TO + 1);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{10'h2CE, 1'b0, 1'b0, 1'b0, 10'h2CE, 1'b1, 10, 4};
    tbl[1] = '{10'h003, 1'b0, 1'b0, 1'b0, 10'h003, 1'b1, EE ? 2 : 10, 4};
    tbl[2] = '{10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 0, 4};
    tbl[3] = '{10'h155, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 0, 0};
    tbl[4] = '{10'h2CE, 1'b0, 1'b1, 1'b0, 10'h2CE, 1'b0, 10, 4};
    tbl[5] = '{10'h0A5, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10, 0};
    tbl[6] = '{10'h001, 1'b0, 1'b0, 1'b0, 10'h001, 1'b1, EE ? 1 : 10, 4};
    tbl[7] = '{10'h3FF, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b1, 10, 4};

    #12;
    chk("rst_attempt", attempt, 0);
    chk("rst_enter", enter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_success", success, 0);
    chk("rst_probe", probe_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run(tbl[i], i);

    // start coinciding with FIN is dropped; next-cycle start is taken
    pw = 10'h2CE; stuck = 1'b0; never_open = 1'b0; force_open = 1'b1;
    clr_lock();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("fin_start_done", done, 1);
    chk("fin_start_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_start_busy", busy, 1);
    chk("idle_start_done", done, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("restart_done", done, 1);
    chk("restart_success", success, 1);

    // asynchronous reset in the middle of a press
    force_open = 1'b0;
    pw = 10'h2CE;
    clr_lock();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!enter && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      chk("press_seen", enter, 1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_enter", enter, 0);
    chk("arst_attempt", attempt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_probe", probe_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(tbl[0], 100);

    // randomized passwords against the reference outcome
    for (int r = 0; r < 10; r++) begin
      logic [W-1:0] p;
      bit           no;
      p  = W'($urandom_range(0, 1023));
      no = ($urandom_range(0, 3) == 0);
      run(model(p, 1'b0, no, 1'b0), 200 + r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/hint_guided_cracker.md
Name: hint_guided_cracker

Overview:
- Drives the combination-lock front end from the user's side: owns the 10-bit attempt bus and the ENTER strobe.
- Reads back the lock's mismatch hint (popcount of attempt XOR password) and its locked flag.
- Recovers the password by greedy single-bit probing, then presses ENTER and confirms the lock opens.
- Sits beside the lock FSM on the MAX10 board top level and replaces the switches and KEY[1] as the lock's input source.

Parameters:
- WIDTH, 10: attempt/password width in bits.
- HINT_W, 4: hint width; must satisfy 2**HINT_W > WIDTH.
- SETTLE, 2: wait cycles after any attempt change before hint is sampled; must be >= 1.
- ENTER_HOLD, 4: cycles enter is held high per press; must be >= 2.
- TIMEOUT, 16: cycles after release to wait for is_locked to fall.

Ports:
- MAX10_CLK1_50  in   1  single clock.
- RESETN  in   1  asynchronous, active-low reset.
- start  in   1  one-cycle request to begin cracking.
- hint  in   HINT_W  mismatch count for the current attempt.
- is_locked  in   1  lock reports LOCKED/OPENING.
- attempt  out  WIDTH  value presented to the lock.
- enter  out  1  active-high ENTER press.
- busy  out  1  high from start acceptance until done.
- done  out  1  level; high after completion until next accepted start.
- success  out  1  valid while done; 1 means the lock was observed open.
- probe_cnt  out  HINT_W  number of bit probes performed in the last run.

Behaviour:
- Reset (asynchronous, RESETN low, any state, including mid-press): attempt=0, enter=0, busy=0, done=0, success=0, probe_cnt=0; state IDLE. enter drops in the same reset assertion.
- States: IDLE, CHECK, INIT, BASE, PROBE, JUDGE, PRESS, WAIT_OPEN, FIN.
- IDLE: start=1 -> CHECK; busy=1; done, success and probe_cnt cleared. start while busy is ignored.
- CHECK (1 cycle): if is_locked=0 -> FIN with success=1. No press is issued, because pressing in OPEN would re-lock with a new password. Otherwise -> INIT.
- INIT: attempt=0, bit index i=0; wait SETTLE cycles -> BASE.
- BASE: base_hint<=hint.
  - If base_hint=0 -> PRESS.
  - Else -> PROBE.
- PROBE: attempt[i] toggled; wait SETTLE cycles; probe_cnt+1 -> JUDGE.
- JUDGE: sample hint.
  - If hint < base_hint: keep the flip; base_hint<=hint.
  - Else: revert attempt[i] in this cycle; base_hint unchanged.
  - Then i+1. If i reaches WIDTH -> PRESS, otherwise -> PROBE.
  - If the revert path is taken, the next probe's SETTLE also covers the restored value.
- Cycles per probe: SETTLE+1.
- PRESS: if base_hint != 0 at entry -> FIN with success=0 (inconsistent hint). Otherwise enter=1 for exactly ENTER_HOLD cycles, then enter=0 -> WAIT_OPEN. attempt is held stable from PRESS entry through FIN.
- WAIT_OPEN: is_locked sampled each cycle.
  - First cycle with is_locked=0 -> FIN with success=1.
  - If TIMEOUT cycles elapse -> FIN with success=0.
- FIN (1 cycle): busy=0, done=1 -> IDLE. done and success hold until the next accepted start.
- Arithmetic:
  - hint comparisons are unsigned over HINT_W bits.
  - probe_cnt saturates at WIDTH and cannot wrap.
  - i counts 0..WIDTH-1, held in a clog2(WIDTH+1)-bit counter.
- Simultaneous events: start in the same cycle as FIN is ignored (FIN takes priority); start arriving in IDLE the next cycle is accepted.

Optional Feature:
- Macro: CRACKER_EARLY_EXIT_EN.
- Defined: JUDGE goes straight to PRESS as soon as base_hint reaches 0, so probe_cnt equals the index of the highest set password bit plus 1.
- Undefined: all WIDTH bits are always probed (probe_cnt=WIDTH when the base hint is nonzero). The final attempt is identical either way.

Decomposition:
- Package cracker_pkg: state enum (cracker_state_t), default constants for WIDTH/HINT_W/SETTLE/ENTER_HOLD/TIMEOUT, and the helper function for the index width.
- One sub-module, cracker_timer: loadable down-counter with a zero flag, shared for the SETTLE, ENTER_HOLD and TIMEOUT waits; same clock and async active-low reset.

Test Plan:
- Bench lock model, password 10'h2CE, hint=popcount(attempt^pw) registered 1 cycle, start -> attempt=10'h2CE, enter high 4 cycles, success=1, probe_cnt=10 (both macro settings).
- Password 10'h003, CRACKER_EARLY_EXIT_EN defined -> probe_cnt=2, attempt=10'h003; macro undefined -> probe_cnt=10, same attempt.
- Password 0 -> no probes, probe_cnt=0, press issued with attempt=0, success=1.
- is_locked=0 at start -> done 2 cycles after start, success=1, enter never asserted, attempt=0.
- Bench never drops is_locked after the press -> success=0 exactly 16 cycles after enter falls; corrupt hint (stuck at 5) -> success=0, no press.
- RESETN pulsed low while enter=1 -> enter, attempt and busy go to 0 asynchronously; a new start afterwards completes normally.
